quic_enc_res: RTL

//  Encoder-side residual former; the inverse of the decoder reconstruction stage.

---
 rtl/quic_enc_res.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/quic_enc_res.sv
// quic_enc_res: encoder-side residual former for the QUIC image coder.
// Takes raw RGB pixels in raster order and predicts each one from its
// left neighbour (a) and the pixel above it (b), which comes from a
// previous-row line buffer. It then emits the folded 8-bit residual code for
// each channel, tagged with column/row and a last-of-frame flag.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        1-cycle pulse: latch width/height, (re)start a frame
//   width, height                image size, sampled on start
//   pix_valid/pix_ready          input pixel handshake
//   pix_r/pix_g/pix_b            input pixel channels
//   out_valid/out_ready          output code handshake
//   ctx_r/ctx_g/ctx_b            folded residual codes
//   out_column, out_row          position of the emitted pixel
//   out_last                     emitted pixel is the last of the frame
//   busy                         frame in progress
//   frame_done                   1-cycle pulse when the frame completes
module quic_enc_res #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_r,
  input  logic [DATA_W-1:0] pix_g,
  input  logic [DATA_W-1:0] pix_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ctx_r,
  output logic [DATA_W-1:0] ctx_g,
  output logic [DATA_W-1:0] ctx_b,
  output logic [15:0]       out_column,
  output logic [15:0]       out_row,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  function automatic logic [DATA_W-1:0] predict(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic row0,
                                                input logic col0);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (row0 && col0)  return '0;
    else if (row0)     return a;
    else if (col0)     return b;
    else               return sum[DATA_W:1];
  endfunction

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] pix,
                                             input logic [DATA_W-1:0] pred);
    logic [DATA_W-1:0] res;
    res = pix - pred;
    return res[DATA_W-1] ? {~res[DATA_W-2:0], 1'b1} : {res[DATA_W-2:0], 1'b0};
  endfunction

  state_e            state_q;
  logic [15:0]       width_q, height_q;
  logic [15:0]       col_q, row_q;
  logic              taken_all_q;
  logic [DATA_W-1:0] a_r_q, a_g_q, a_b_q;
  logic [DATA_W-1:0] b_r_q, b_g_q, b_b_q;
  logic              out_valid_q, out_last_q, busy_q, frame_done_q;
  logic [DATA_W-1:0] ctx_r_q, ctx_g_q, ctx_b_q;
  logic [15:0]       out_column_q, out_row_q;

  logic [DATA_W-1:0] lb_r [DEPTH];
  logic [DATA_W-1:0] lb_g [DEPTH];
  logic [DATA_W-1:0] lb_b [DEPTH];

  logic              accept, out_fire, col_end, row_end, row0, col0;
  logic [15:0]       col_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] ctx_r_d, ctx_g_d, ctx_b_d;

  assign pix_ready = (state_q == S_RUN) & (~out_valid_q | out_ready) & ~taken_all_q;
  // A start pulse wins over a coincident pixel handshake.
  assign accept    = pix_valid & pix_ready & ~start;
  assign out_fire  = out_valid_q & out_ready;
  assign col_end   = (col_q == width_q - 16'd1);
  assign row_end   = (row_q == height_q - 16'd1);
  assign row0      = (row_q == '0);
  assign col0      = (col_q == '0);
  assign col_nxt   = col_end ? '0 : col_q + 16'd1;
  assign wr_addr   = col_q[ADDR_W-1:0];
  assign rd_addr   = col_nxt[ADDR_W-1:0];

  always_comb begin
    ctx_r_d = fold(pix_r, predict(a_r_q, b_r_q, row0, col0));
    ctx_g_d = fold(pix_g, predict(a_g_q, b_g_q, row0, col0));
    ctx_b_d = fold(pix_b, predict(a_b_q, b_b_q, row0, col0));
  end

  // Previous-row buffers: written at col, read for col+1 on the same accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_r[wr_addr] <= pix_r;
      lb_g[wr_addr] <= pix_g;
      lb_b[wr_addr] <= pix_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      taken_all_q  <= 1'b0;
      a_r_q        <= '0;
      a_g_q        <= '0;
      a_b_q        <= '0;
      b_r_q        <= '0;
      b_g_q        <= '0;
      b_b_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ctx_r_q      <= '0;
      ctx_g_q      <= '0;
      ctx_b_q      <= '0;
      out_column_q <= '0;
      out_row_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (start) begin
        width_q     <= width;
        height_q    <= height;
        col_q       <= '0;
        row_q       <= '0;
        taken_all_q <= 1'b0;
        out_valid_q <= 1'b0;
        if (width == '0 || height == '0) begin
          state_q      <= S_DONE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end else begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_RUN: begin
            if (accept) begin
              out_valid_q  <= 1'b1;
              ctx_r_q      <= ctx_r_d;
              ctx_g_q      <= ctx_g_d;
              ctx_b_q      <= ctx_b_d;
              out_column_q <= col_q;
              out_row_q    <= row_q;
              out_last_q   <= col_end & row_end;
              a_r_q        <= pix_r;
              a_g_q        <= pix_g;
              a_b_q        <= pix_b;
              // With width 1 the next read hits the address being written;
              // the RAM returns the old word, so forward the new pixel.
              b_r_q        <= (rd_addr == wr_addr) ? pix_r : lb_r[rd_addr];
              b_g_q        <= (rd_addr == wr_addr) ? pix_g : lb_g[rd_addr];
              b_b_q        <= (rd_addr == wr_addr) ? pix_b : lb_b[rd_addr];
              col_q        <= col_nxt;
              if (col_end) begin
                if (row_end) taken_all_q <= 1'b1;
                else         row_q       <= row_q + 16'd1;
              end
            end else if (out_fire) begin
              out_valid_q <= 1'b0;
            end
            if (out_fire && out_last_q) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign ctx_r      = ctx_r_q;
  assign ctx_g      = ctx_g_q;
  assign ctx_b      = ctx_b_q;
  assign out_column = out_column_q;
  assign out_row    = out_row_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
